// File: rtl/clk_div_sched_pkg.sv
// Shared types and helpers for the programmable clock-pattern controller.
package clk_div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned MIN_PERIOD = 2;

    // A config is usable only if the period has room for at least one high
    // and one low cycle. Callers zero-extend their fields to 32 bits, so the
    // checks are done on the full value with no truncation.
    function automatic logic cfg_legal(input logic [31:0] period, input logic [31:0] high);
        return (period >= MIN_PERIOD) && (high >= 32'd1) && (high <= period - 32'd1);
    endfunction

endpackage

// File: rtl/clk_div_cfg_hold.sv
// Config handshake and pending-config holder. Validates offered configs,
// parks a legal one until the controller can apply it, and presents the
// values to apply together with a one-cycle apply strobe.
module clk_div_cfg_hold
    import clk_div_sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             apply_ok,    // controller is idle or at a period wrap
    input  logic             bypass_ok,   // controller is idle and starting this edge
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             busy,
    output logic             apply,
    output logic [CNT_W-1:0] new_period,
    output logic [CNT_W-1:0] new_high
);

    logic             legal;
    logic             xfer;
    logic             take_pending;
    logic             take_direct;
    logic             park;
    logic [CNT_W-1:0] pend_period;
    logic [CNT_W-1:0] pend_high;

    assign legal        = cfg_legal(32'(cfg_period), 32'(cfg_high));
    assign cfg_ready    = ~busy;
    assign xfer         = cfg_valid & cfg_ready;
    assign take_pending = busy & apply_ok;
    // A legal config offered on the edge the controller leaves IDLE goes
    // straight into force so that the very first period uses it.
    assign take_direct  = xfer & legal & bypass_ok;
    assign park         = xfer & legal & ~bypass_ok;
    assign apply        = take_pending | take_direct;
    assign new_period   = busy ? pend_period : cfg_period;
    assign new_high     = busy ? pend_high   : cfg_high;

    // Busy flag and error pulse; a transfer can only happen while not busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= xfer & ~legal;
            if (take_pending) begin
                busy <= 1'b0;
            end else if (park) begin
                busy <= 1'b1;
            end
        end
    end

    // Pending config data; only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (park) begin
            pend_period <= cfg_period;
            pend_high   <= cfg_high;
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Programmable divided-clock generator with start/stop sequencing and
// period-boundary reconfiguration.
module clk_div_sched
    import clk_div_sched_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_HIGH   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             period_start,
    output logic             busy,
    output logic [CNT_W-1:0] cur_period,
    output logic [CNT_W-1:0] cur_high
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             clk_n;
    logic             ps_n;
    logic [CNT_W-1:0] per_n, high_n;
    logic             wrap;
    logic             apply_ok;
    logic             bypass_ok;
    logic             apply;
    logic [CNT_W-1:0] new_period, new_high;

    assign wrap      = (state != IDLE) && (cnt == cur_period - ONE);
    assign apply_ok  = (state == IDLE) || wrap;
    assign bypass_ok = (state == IDLE) && en;

    clk_div_cfg_hold #(
        .CNT_W (CNT_W)
    ) u_cfg_hold (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .apply_ok   (apply_ok),
        .bypass_ok  (bypass_ok),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .apply      (apply),
        .new_period (new_period),
        .new_high   (new_high)
    );

    // Next-state, counter and waveform decode; new settings only land at
    // a wrap or in IDLE, so the values in force never change mid-period.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clk_n   = clk_out;
        ps_n    = 1'b0;
        per_n   = cur_period;
        high_n  = cur_high;
        if (apply) begin
            per_n  = new_period;
            high_n = new_high;
        end
        case (state)
            IDLE: begin
                cnt_n = '0;
                clk_n = 1'b0;
                if (en) begin
                    state_n = RUN;
                    clk_n   = 1'b1;
                    ps_n    = 1'b1;
                end
            end
            RUN, DRAIN: begin
                cnt_n = wrap ? '0 : cnt + ONE;
                clk_n = (cnt_n < high_n);
                ps_n  = (cnt_n == '0);
                if (state == RUN) begin
                    if (!en) state_n = DRAIN;
                end else if (wrap && !en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    clk_n   = 1'b0;
                    ps_n    = 1'b0;
                end else if (en) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                clk_n   = 1'b0;
            end
        endcase
    end

    // State, counter, registered waveform and the settings in force.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            clk_out      <= 1'b0;
            period_start <= 1'b0;
            cur_period   <= CNT_W'(DEF_PERIOD);
            cur_high     <= CNT_W'(DEF_HIGH);
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            clk_out      <= clk_n;
            period_start <= ps_n;
            cur_period   <= per_n;
            cur_high     <= high_n;
        end
    end

endmodule
